adc_word_tx: RTL and testbench
==============================

Name: adc_word_tx

Overview:
Serial transmitter for captured 10-bit ADC sample words, sending them off-chip in UART-style frames. It accepts a parallel word from the capture register stage through a valid/ready handshake and holds one word in a buffer. It then serializes the word LSB-first with a start bit, optional even parity and stop bit(s). The one-word buffer allows back-to-back frames with no idle gap.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
PARITY_EN, 1, 1 = append an even-parity bit after data bit 9; 0 = no parity bit.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic is rising-edge.
reset  input  1  asynchronous, active-low reset.
din  input  10  sample word to transmit.
din_valid  input  1  din is valid this cycle.
din_ready  output  1  holding buffer is empty; a word is accepted on a cycle where din_valid and din_ready are both 1.
tx  output  1  serial line; idles high.
busy  output  1  a frame is being shifted out.
frame_done  output  1  one-cycle pulse on the last clk of the final stop bit.

Behaviour:
- Reset (reset=0, asynchronous): tx=1, busy=0, frame_done=0, din_ready=1, holding buffer empty, shifter idle, bit and cycle counters cleared. Reset asserted mid-frame aborts the frame at once; tx returns high without waiting for a clock edge. After release, the block is idle and sends nothing until a new word is accepted.
- Datapath: holding buffer (10 bits + full flag) feeds a shift register; a cycle counter counts 0..CLKS_PER_BIT-1; a bit counter counts frame bit positions.
- Acceptance:
  - Capture din into the holding buffer on a handshake.
  - din_ready = !buffer_full. It is registered and drops the cycle after acceptance.
  - din_valid with din_ready=0 is ignored; the upstream block holds the word.
- States:
  - IDLE: tx=1, busy=0. If the buffer is full, move it to the shifter, compute parity and go to START on the next edge. The buffer frees in the same cycle.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx = shifter bit 0 for CLKS_PER_BIT cycles per bit; shift right after each bit; 10 bits total.
  - PARITY (only if PARITY_EN=1): tx = XOR of all 10 bits, for CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame timing:
  - Frame length = CLKS_PER_BIT*(11+PARITY_EN+STOP_BITS) cycles.
  - Latency: when a word is accepted at edge N with the shifter idle, tx falls at edge N+2.
- End of frame:
  - frame_done=1 for exactly one cycle, during the last STOP cycle.
  - If the buffer is full at that point, the next START begins on the following cycle with no idle cycle, so tx goes 1→0 directly.
  - Otherwise the block returns to IDLE.
- Simultaneous events: a word accepted in the same cycle the shifter loads from the buffer is legal, because din_ready was already 1. The new word is held until the current frame ends.
- busy=1 from the first START cycle through the last STOP cycle, continuous across back-to-back frames.
- Changes on din while no handshake occurs have no effect on tx.

Test Plan:
1. Reset release, no din_valid for 200 cycles -> tx=1, busy=0, din_ready=1, frame_done never pulses.
2. Single word, CLKS_PER_BIT=4, PARITY_EN=1, STOP_BITS=1, din=10'h2A5 -> frame of 52 cycles on tx:
   - start 0;
   - data bits LSB-first 1,0,1,0,0,1,0,1,0,1;
   - parity 1;
   - stop 1;
   - frame_done pulses once on cycle 52; tx falls 2 cycles after acceptance.
3. Two words 10'h3FF then 10'h000, second presented during the first frame:
   - second word accepted while the first frame shifts;
   - second frame starts immediately after the first stop bit with no idle cycle;
   - parity bits are 0 then 0; busy stays high across both frames.
4. Back-pressure: three words presented back-to-back -> din_ready=0 after the second acceptance until the first frame ends; the third word is transmitted intact and in order.
5. Reset asserted at cycle 20 of a frame -> tx=1 immediately without a clock edge, busy=0, din_ready=1; no frame_done pulse; the next word sends a full, correct frame.
6. PARITY_EN=0, STOP_BITS=2, CLKS_PER_BIT=2, din=10'h001 -> 26-cycle frame: start, data 1 then nine 0s, two stop bits, no parity bit.

Source files
------------

// File: rtl/adc_word_tx.sv
`timescale 1ns/1ps
// adc_word_tx: one-word buffered, UART-style serializer for 10-bit ADC samples.
// Frame: start bit, 10 data bits LSB-first, optional even parity, 1 or 2 stop bits.
module adc_word_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [15:0] CYC_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [3:0]  DATA_LAST = 4'd9;

  state_t      state, state_next;
  logic [9:0]  buf_data, shifter;
  logic        buf_full, buf_full_next, parity_bit;
  logic [15:0] cyc_cnt;
  logic [3:0]  bit_cnt;
  logic        accept, cyc_last, frame_end, load;
  logic        tx_next, busy_next, done_next;

  assign accept        = din_valid && din_ready;
  assign cyc_last      = (cyc_cnt == CYC_LAST);
  assign frame_end     = (state == S_STOP) && cyc_last && (bit_cnt == STOP_LAST);
  // The buffer drains into the shifter from idle, or straight from the last stop cycle.
  assign load          = buf_full && ((state == S_IDLE) || frame_end);
  assign buf_full_next = accept || (buf_full && !load);

  // NOTE: every flop uses <= so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full  <= 1'b0;
      din_ready <= 1'b1;
      buf_data  <= '0;
    end else begin
      if (accept) buf_data <= din;
      buf_full  <= buf_full_next;
      din_ready <= !buf_full_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: assign a default before the case so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (buf_full) state_next = S_START;
      S_START:  if (cyc_last) state_next = S_DATA;
      S_DATA:   if (cyc_last && (bit_cnt == DATA_LAST))
                  state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (cyc_last) state_next = S_STOP;
      S_STOP:   if (frame_end) state_next = buf_full ? S_START : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      parity_bit <= 1'b0;
    end else begin
      if ((state == S_IDLE) || cyc_last) cyc_cnt <= '0;
      else                               cyc_cnt <= cyc_cnt + 16'd1;

      if (state_next != state) bit_cnt <= '0;
      else if (cyc_last)       bit_cnt <= bit_cnt + 4'd1;

      if (load) begin
        shifter    <= buf_data;
        parity_bit <= ^buf_data;
      end else if ((state == S_DATA) && cyc_last) begin
        shifter <= {1'b0, shifter[9:1]};
      end
    end
  end

  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state != S_IDLE);
    done_next = frame_end;
    case (state)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shifter[0];
      S_PARITY: tx_next = parity_bit;
      default:  tx_next = 1'b1;
    endcase
  end

  // Registered outputs keep tx glitch-free; the async reset still forces the line high at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx         <= tx_next;
      busy       <= busy_next;
      frame_done <= done_next;
    end
  end

endmodule

// File: tb/tb_adc_word_tx.sv
`timescale 1ns/1ps
// tb_adc_word_tx: directed and randomized checks of two adc_word_tx configurations
// against a frame-schedule model derived from the line protocol rules.
module tb_adc_word_tx;

  typedef struct {
    int         acc;
    int         start;
    logic [9:0] word;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] din = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, tx_a, busy_a, done_a;
  logic       ready_b, tx_b, busy_b, done_b;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  string      tname = "init";

  bit         sel = 1'b0;
  int         m_clk = 4, m_par = 1, m_stop = 1, m_len = 52;
  frame_t     sched[$];
  logic [9:0] pend[$];
  int         line_free = 0;
  bit         acc_ok = 1'b1;

  adc_word_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .din(din), .din_valid(valid_a),
    .din_ready(ready_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a)
  );

  adc_word_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .din(din), .din_valid(valid_b),
    .din_ready(ready_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string what, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0h expected %0h at cycle %0d", tname, what, obs, exp, cyc);
    end
  endtask

  // Value on the line during frame slot 'slot' (0 = start bit).
  function automatic logic slot_bit(input logic [9:0] w, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 10) return w[slot-1];
    if ((m_par != 0) && (slot == 11)) return (($countones(w) % 2) == 1);
    return 1'b1;
  endfunction

  task automatic model_clear();
    sched.delete();
    pend.delete();
    line_free = 0;
    acc_ok = 1'b1;
  endtask

  task automatic configure(input bit s, input int c, input int p, input int st);
    sel = s;
    m_clk = c;
    m_par = p;
    m_stop = st;
    m_len = c * (11 + p + st);
    model_clear();
  endtask

  // One clock: apply handshake to the model, drive the next inputs, then compare at negedge.
  task automatic step();
    logic   vld, vld_now;
    logic   e_tx, e_busy, e_done, e_ready;
    logic   o_tx, o_busy, o_done, o_ready;
    int     s;
    frame_t f;
    vld = sel ? valid_b : valid_a;
    @(posedge clk);
    cyc++;
    if (vld && acc_ok) begin
      s = (cyc + 2 > line_free) ? cyc + 2 : line_free;
      f.acc = cyc;
      f.start = s;
      f.word = din;
      sched.push_back(f);
      line_free = s + m_len;
      void'(pend.pop_front());
    end
    #1;
    if (pend.size() > 0) begin
      din = pend[0];
      vld_now = 1'b1;
    end else begin
      din = 10'($urandom);
      vld_now = 1'b0;
    end
    valid_a = vld_now && !sel;
    valid_b = vld_now && sel;
    @(negedge clk);
    e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ready = 1'b1;
    foreach (sched[i]) begin
      if ((cyc >= sched[i].start) && (cyc < sched[i].start + m_len)) begin
        e_tx = slot_bit(sched[i].word, (cyc - sched[i].start) / m_clk);
        e_busy = 1'b1;
        e_done = (cyc == sched[i].start + m_len - 1);
      end
      if ((cyc >= sched[i].acc) && (cyc < sched[i].start - 1)) e_ready = 1'b0;
    end
    o_tx    = sel ? tx_b    : tx_a;
    o_busy  = sel ? busy_b  : busy_a;
    o_done  = sel ? done_b  : done_a;
    o_ready = sel ? ready_b : ready_a;
    check("tx", 16'(o_tx), 16'(e_tx));
    check("busy", 16'(o_busy), 16'(e_busy));
    check("frame_done", 16'(o_done), 16'(e_done));
    check("din_ready", 16'(o_ready), 16'(e_ready));
    if (o_done === 1'b1) done_cnt++;
    acc_ok = e_ready;
  endtask

  initial begin
    logic [9:0] w;
    configure(1'b0, 4, 1, 1);

    tname = "reset_idle";
    repeat (3) step();
    reset = 1'b1;
    done_cnt = 0;
    repeat (200) step();
    check("done_count", 16'(done_cnt), 16'd0);

    tname = "single_2a5";
    done_cnt = 0;
    pend.push_back(10'h2A5);
    repeat (60) step();
    check("done_count", 16'(done_cnt), 16'd1);

    tname = "b2b_3ff_000";
    done_cnt = 0;
    pend.push_back(10'h3FF);
    pend.push_back(10'h000);
    repeat (120) step();
    check("done_count", 16'(done_cnt), 16'd2);

    tname = "backpressure3";
    done_cnt = 0;
    repeat (3) pend.push_back(10'($urandom));
    repeat (170) step();
    check("done_count", 16'(done_cnt), 16'd3);

    tname = "random_a";
    done_cnt = 0;
    repeat (5) pend.push_back(10'($urandom));
    repeat (270) step();
    check("done_count", 16'(done_cnt), 16'd5);

    tname = "midframe_reset";
    w = 10'($urandom) & 10'h3EF;
    pend.push_back(w);
    repeat (24) step();
    #2 reset = 1'b0;
    #1;
    check("async_tx", 16'(tx_a), 16'd1);
    check("async_busy", 16'(busy_a), 16'd0);
    check("async_ready", 16'(ready_a), 16'd1);
    check("async_done", 16'(done_a), 16'd0);
    model_clear();
    repeat (3) step();
    reset = 1'b1;
    done_cnt = 0;
    repeat (20) step();
    check("done_count_after_reset", 16'(done_cnt), 16'd0);
    pend.push_back(10'($urandom));
    repeat (60) step();
    check("done_count", 16'(done_cnt), 16'd1);

    tname = "nopar_2stop_001";
    configure(1'b1, 2, 0, 2);
    done_cnt = 0;
    pend.push_back(10'h001);
    repeat (32) step();
    check("done_count", 16'(done_cnt), 16'd1);

    tname = "random_b";
    done_cnt = 0;
    repeat (4) pend.push_back(10'($urandom));
    repeat (114) step();
    check("done_count", 16'(done_cnt), 16'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
